if_fetch_ctrl: RTL
==================

# if_fetch_ctrl

Instruction-fetch front end that answers the pipeline's flush/cancel requests on the IF side. Issues instruction-SRAM requests (req/addr_ok/data_ok handshake), tracks in-flight fetches, discards responses belonging to requests cancelled by a branch, exception, ertn or fetch-again flush, and buffers returned instructions until ID accepts them. Sits between the PC generator and the IF/ID boundary.

## Interface

- FETCH_DEPTH, 2, maximum in-flight requests plus buffered instructions (≥1)
- PC_W, 32, PC width
- INST_W, 32, instruction width

- aclk  in  1  clock, all state on rising edge
- resetn  in  1  synchronous, active-low reset
- cancel  in  1  flush from hazard unit (IFFlush | IDFlush); kills all buffered and in-flight fetches
- pc_valid  in  1  PC generator has a next PC
- pc_in  in  PC_W  next fetch PC
- pc_accept  out  1  pc_in taken this cycle; PC generator advances
- inst_req  out  1  SRAM request
- inst_addr  out  PC_W  request address (= pc_in)
- inst_addr_ok  in  1  request accepted
- inst_data_ok  in  1  response valid, in request order
- inst_rdata  in  INST_W  response data
- id_allow_in  in  1  ID accepts this cycle
- if_valid_out  out  1  instruction available to ID
- if_pc_out  out  PC_W  PC of head instruction
- if_inst_out  out  INST_W  head instruction

## Operation

- State: pc FIFO (PCs of in-flight requests, depth FETCH_DEPTH), output FIFO ({pc,inst}, depth FETCH_DEPTH), discard_cnt (width $clog2(FETCH_DEPTH+1)).
- Room: inflight + buffered + (discard_cnt counted inside inflight) < FETCH_DEPTH. Guarantees output FIFO never overflows.
- inst_req = pc_valid & room & ~cancel; inst_addr = pc_in; pc_accept = inst_req & inst_addr_ok; on pc_accept push pc_in into pc FIFO.
- On inst_data_ok: pop pc FIFO (always). If discard_cnt ≠ 0 or cancel: drop response, decrement discard_cnt if ≠ 0. Else push {popped pc, inst_rdata} into output FIFO.
- if_valid_out = output FIFO non-empty & ~cancel; pop on if_valid_out & id_allow_in.
- On cancel: output FIFO cleared; discard_cnt <= inflight − (inst_data_ok ? 1 : 0) + (existing discard_cnt already included in inflight, i.e. discard_cnt becomes all remaining in-flight entries). No new request issued that cycle.
- inst_data_ok with empty pc FIFO is a protocol error; assertion, no state change.
- Simultaneous push and pop on either FIFO in one cycle allowed, including when full.

## Timing

- Reset (resetn=0 at edge): FIFOs empty, discard_cnt=0; outputs inst_req=0, pc_accept=0, if_valid_out=0, if_pc_out=0, if_inst_out=0. Mid-operation reset drops all state; SRAM side is reset in the same cycle.
- inst_req, inst_addr, pc_accept combinational from inputs and state.
- Latency: data_ok at cycle N → if_valid_out at N+1 (registered FIFO head), earliest.
- Best-case throughput one instruction per cycle when addr_ok and data_ok are continuous and FETCH_DEPTH ≥ 2.
- cancel at cycle N: if_valid_out low at N; no output of pre-cancel fetches at any later cycle; first post-cancel request may issue at N+1.
- Response arriving in the same cycle as cancel is dropped.

## Structure

- cpuDefine package: FETCH_DEPTH default constant, typedef FetchEntry {logic [PC_W-1:0] pc; logic [INST_W-1:0] inst;}.
- Sub-module fetch_fifo: synchronous FIFO (parameters WIDTH, DEPTH; push, pop, clear, full, empty, count); instantiated for pc FIFO and output FIFO.
- Top holds room logic, discard counter, handshake gating.

## Test plan

- Streaming: addr_ok=1, data_ok one cycle later, pc 0x1c000000,+4,… → ID sees same PCs in order, one per cycle, inst matching.
- Backpressure: id_allow_in=0 for 5 cycles → at most FETCH_DEPTH entries held, inst_req low when full, no loss or duplication on release.
- Cancel with 2 in flight: cancel at cycle N, then two data_ok → both dropped, discard_cnt 2→1→0; next request PC 0x1c000100 delivered as first post-cancel instruction.
- Cancel same cycle as data_ok and a buffered head → head and response both dropped, if_valid_out=0 at N.
- addr_ok held low 3 cycles → inst_req/inst_addr stable, pc_accept only on the addr_ok cycle.
- Reset asserted with 1 in flight and 1 buffered → next cycle all outputs 0, FIFOs empty.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpuDefine: shared fetch constants and the buffered-instruction entry type. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package cpuDefine;

  localparam int FETCH_DEPTH_DEF = 2;
  localparam int PC_WIDTH        = 32;
  localparam int INST_WIDTH      = 32;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INST_WIDTH-1:0] inst;
  } FetchEntry;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl_if: PC generator, instruction SRAM and IF/ID signals of the fetch front end. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface if_fetch_ctrl_if #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
);

  logic              cancel;
  logic              pc_valid;
  logic [PC_W-1:0]   pc_in;
  logic              pc_accept;
  logic              inst_req;
  logic [PC_W-1:0]   inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [INST_W-1:0] inst_rdata;
  logic              id_allow_in;
  logic              if_valid_out;
  logic [PC_W-1:0]   if_pc_out;
  logic [INST_W-1:0] if_inst_out;

  // Fetch controller side
  modport master (
    input  cancel, pc_valid, pc_in, inst_addr_ok, inst_data_ok, inst_rdata, id_allow_in,
    output pc_accept, inst_req, inst_addr, if_valid_out, if_pc_out, if_inst_out
  );

  // Environment side: PC generator, SRAM and ID stage
  modport slave (
    output cancel, pc_valid, pc_in, inst_addr_ok, inst_data_ok, inst_rdata, id_allow_in,
    input  pc_accept, inst_req, inst_addr, if_valid_out, if_pc_out, if_inst_out
  );

endinterface

`default_nettype wire

// File: rtl/if_fetch_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo: synchronous FIFO with clear; push into a full FIFO is legal alongside a pop. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign w_do_pop  = pop_i & ~empty_o;
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (w_do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (w_do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl: IF-side fetch front end; tracks SRAM fetches, drops cancelled responses. Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module if_fetch_ctrl
  import cpuDefine::*;
#(
  parameter int FETCH_DEPTH = FETCH_DEPTH_DEF,
  parameter int PC_W        = PC_WIDTH,
  parameter int INST_W      = INST_WIDTH
) (
  input  logic            aclk,
  input  logic            resetn,
  if_fetch_ctrl_if.master bus
);

  localparam int CNT_W = cnt_width(FETCH_DEPTH);
  localparam int SUM_W = CNT_W + 1;

  if (PC_W != PC_WIDTH || INST_W != INST_WIDTH) begin : g_width_check
    $error("if_fetch_ctrl: PC_W/INST_W must match the FetchEntry widths");
  end

  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] w_pc_cnt, w_out_cnt;
  logic             w_pc_empty, w_pc_full;
  logic             w_out_empty, w_out_full;
  logic [PC_W-1:0]  w_pc_head;
  FetchEntry        w_out_head;
  FetchEntry        w_out_push_entry;
  logic [SUM_W-1:0] w_occupancy;
  logic             w_room;
  logic             w_req;
  logic             w_accept;
  logic             w_resp;
  logic             w_keep;
  logic             w_if_valid;
  logic             w_out_pop;

  assign w_if_valid = resetn & ~w_out_empty & ~bus.cancel;
  assign w_out_pop  = w_if_valid & bus.id_allow_in;

  // A slot freed by ID in this cycle may be reused at once, giving one fetch per cycle.
  assign w_occupancy = SUM_W'(w_pc_cnt) + SUM_W'(w_out_cnt) - SUM_W'(w_out_pop);
  assign w_room      = (w_occupancy < SUM_W'(FETCH_DEPTH));

  assign w_req    = resetn & bus.pc_valid & w_room & ~bus.cancel;
  assign w_accept = w_req & bus.inst_addr_ok;
  assign w_resp   = resetn & bus.inst_data_ok & ~w_pc_empty;
  assign w_keep   = w_resp & ~bus.cancel & (discard_q == '0);

  assign w_out_push_entry.pc   = w_pc_head;
  assign w_out_push_entry.inst = bus.inst_rdata;

  assign bus.inst_req     = w_req;
  assign bus.inst_addr    = bus.pc_in;
  assign bus.pc_accept    = w_accept;
  assign bus.if_valid_out = w_if_valid;
  assign bus.if_pc_out    = w_out_empty ? '0 : w_out_head.pc;
  assign bus.if_inst_out  = w_out_empty ? '0 : w_out_head.inst;

  // On cancel every request still outstanding after this cycle's response becomes a discard.
  always_comb begin
    discard_d = discard_q;
    if (bus.cancel) begin
      discard_d = w_pc_cnt - CNT_W'(w_resp);
    end else if (w_resp && discard_q != '0) begin
      discard_d = discard_q - CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      discard_q <= '0;
    end else begin
      discard_q <= discard_d;
    end
  end

  fetch_fifo #(
    .WIDTH (PC_W),
    .DEPTH (FETCH_DEPTH)
  ) u_pc_fifo (
    .clk_i   (aclk),
    .rst_ni  (resetn),
    .clear_i (1'b0),
    .push_i  (w_accept),
    .data_i  (bus.pc_in),
    .pop_i   (w_resp),
    .data_o  (w_pc_head),
    .full_o  (w_pc_full),
    .empty_o (w_pc_empty),
    .count_o (w_pc_cnt)
  );

  fetch_fifo #(
    .WIDTH ($bits(FetchEntry)),
    .DEPTH (FETCH_DEPTH)
  ) u_out_fifo (
    .clk_i   (aclk),
    .rst_ni  (resetn),
    .clear_i (bus.cancel),
    .push_i  (w_keep),
    .data_i  (w_out_push_entry),
    .pop_i   (w_out_pop),
    .data_o  (w_out_head),
    .full_o  (w_out_full),
    .empty_o (w_out_empty),
    .count_o (w_out_cnt)
  );

  a_resp_has_request: assert property (@(posedge aclk) disable iff (!resetn)
    bus.inst_data_ok |-> !w_pc_empty);

  a_pc_no_overflow: assert property (@(posedge aclk) disable iff (!resetn)
    (w_pc_full && w_accept) |-> w_resp);

  a_out_no_overflow: assert property (@(posedge aclk) disable iff (!resetn)
    (w_out_full && w_keep) |-> w_out_pop);

endmodule

`default_nettype wire
